// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: NREQ requesters share one FIFO write port, and
// each grant lasts up to BURST beats before the grant is handed to the next requester.
module fifo_wr_arb #(
  parameter int DW    = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 8,
  parameter int IW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data,
  input  logic                 fifo_full,
  output logic [NREQ-1:0]      gnt,
  output logic                 push,
  output logic [DW-1:0]        din,
  output logic                 busy,
  output logic [IW-1:0]        owner
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NREQ-1:0] gnt_s;
  logic [DW-1:0]   din_s;
  logic            owner_req_s;
  logic            xfer_s;
  logic            last_beat_s;

  // First set request bit at or above ptr, wrapping modulo NREQ.
  function automatic logic [IW-1:0] pick_next(input logic [NREQ-1:0] r, input logic [IW-1:0] ptr);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      else             idx = idx;
      if (!found && r[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end else begin
        sel   = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] o);
    if (int'(o) == NREQ - 1) return '0;
    else                     return o + IW'(1);
  endfunction

  assign owner_req_s = req[owner_q];
  assign xfer_s      = push;
  assign last_beat_s = (beat_cnt_q == CW'(BURST - 1));

  // Grant only the owner's beat, and only when the FIFO can take it.
  always_comb begin
    gnt_s = '0;
    din_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_q == S_BURST) && (owner_q == IW'(i)) && req[i] && !fifo_full) gnt_s[i] = 1'b1;
      else                                                                    gnt_s[i] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      din_s = din_s | (data[i*DW +: DW] & {DW{gnt_s[i]}});
    end
  end

  // Next-state logic for arbitration, burst length and rotation pointer.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d    = pick_next(req, rr_ptr_q);
          beat_cnt_d = '0;
          state_d    = S_BURST;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_BURST: begin
        if (!owner_req_s) begin
          state_d  = S_IDLE;
          rr_ptr_d = inc_wrap(owner_q);
        end else if (xfer_s) begin
          if (last_beat_s) begin
            state_d  = S_IDLE;
            rr_ptr_d = inc_wrap(owner_q);
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end else begin
          // fifo_full stall: hold everything, no timeout
          state_d = S_BURST;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt   = gnt_s;
  assign push  = |gnt_s;
  assign din   = din_s;
  assign busy  = (state_q == S_BURST);
  assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: a grant-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, then random traffic.
module tb_fifo_wr_arb;

  localparam int DW    = 32;
  localparam int NREQ  = 4;
  localparam int BURST = 8;
  localparam int IW    = 2;

  logic               clk;
  logic               rst_v;
  logic [NREQ-1:0]    req_v;
  logic [NREQ*DW-1:0] data_v;
  logic               full_v;
  logic [NREQ-1:0]    gnt;
  logic               push;
  logic [DW-1:0]      din;
  logic               busy;
  logic [IW-1:0]      owner;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: who holds the grant, beats moved, where the search restarts
  bit m_active;
  int m_owner;
  int m_beats;
  int m_ptr;

  fifo_wr_arb #(.DW(DW), .NREQ(NREQ), .BURST(BURST), .IW(IW)) dut (
    .clk(clk), .rst(rst_v), .req(req_v), .data(data_v), .fifo_full(full_v),
    .gnt(gnt), .push(push), .din(din), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_beats  = 0;
    m_ptr    = 0;
  endtask

  task automatic model_update();
    bit found;
    if (!rst_v) begin
      model_reset();
    end else if (!m_active) begin
      if (req_v != '0) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && req_v[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            found   = 1'b1;
          end
        end
        m_active = 1'b1;
        m_beats  = 0;
      end
    end else if (!req_v[m_owner]) begin
      m_active = 1'b0;
      m_ptr    = (m_owner + 1) % NREQ;
    end else if (!full_v) begin
      m_beats++;
      if (m_beats == BURST) begin
        m_active = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic compare_model();
    logic [NREQ-1:0] e_gnt;
    logic [DW-1:0]   e_din;
    e_gnt = '0;
    e_din = '0;
    if (rst_v && m_active && req_v[m_owner] && !full_v) begin
      e_gnt[m_owner] = 1'b1;
      e_din          = data_v[m_owner*DW +: DW];
    end
    chk("gnt",   64'(gnt),  64'(e_gnt));
    chk("push",  64'(push), 64'(e_gnt != '0));
    chk("din",   64'(din),  64'(e_din));
    chk("busy",  64'(busy), 64'(rst_v && m_active));
    chk("owner", 64'(owner), 64'(m_owner));
    chk("overflow", 64'(push & full_v), 64'(0));
  endtask

  task automatic settle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_v  = 1'b0;
    model_reset();
    req_v  = '0;
    full_v = 1'b0;
    data_v = '0;
    repeat (2) begin
      settle();
      advance();
    end
    rst_v = 1'b1;
  endtask

  initial begin
    int npush;
    int pre;
    int post;
    rst_v  = 1'b0;
    req_v  = '0;
    full_v = 1'b0;
    data_v = '0;
    model_reset();

    // single requester, data tracks the number of beats already pushed
    do_reset();
    req_v = 4'b0001;
    npush = 0;
    for (int c = 0; c < 11; c++) begin
      data_v[DW-1:0] = 32'hA0 + 32'(npush);
      settle();
      if (c == 0)  chk("t1_idle_c0", 64'(busy), 64'd0);
      if (c == 1)  chk("t1_busy_c1", 64'(busy), 64'd1);
      if (c == 1)  chk("t1_din_c1", 64'(din), 64'hA0);
      if (c == 8)  chk("t1_din_c8", 64'(din), 64'hA7);
      if (c == 9)  chk("t1_bubble", 64'(push), 64'd0);
      if (c == 10) chk("t1_resume", 64'(din), 64'hA8);
      if (push) npush++;
      advance();
    end
    chk("t1_npush", 64'(npush), 64'd9);

    // all four requesting: full rotation 0,1,2,3,0 with a bubble between bursts
    do_reset();
    req_v = 4'b1111;
    npush = 0;
    for (int c = 0; c < 39; c++) begin
      settle();
      if (c < 36 && push) npush++;
      if (c % 9 == 1) begin
        chk("t2_owner", 64'(owner), 64'((c / 9) % NREQ));
        chk("t2_busy", 64'(busy), 64'd1);
      end
      if (c == 36) chk("t2_bubble", 64'(busy), 64'd0);
      advance();
    end
    chk("t2_npush", 64'(npush), 64'd32);

    // back-pressure on owner 2 after three beats
    do_reset();
    req_v = 4'b0100;
    pre   = 0;
    post  = 0;
    for (int c = 0; c < 16; c++) begin
      full_v = (c >= 4 && c <= 8);
      settle();
      if (full_v) begin
        chk("t3_stall_push", 64'(push), 64'd0);
        chk("t3_stall_busy", 64'(busy), 64'd1);
        chk("t3_stall_owner", 64'(owner), 64'd2);
      end
      if (c < 4 && push) pre++;
      if (c >= 9 && c <= 13 && push) post++;
      if (c == 14) chk("t3_exit", 64'(busy), 64'd0);
      advance();
    end
    chk("t3_pre", 64'(pre), 64'd3);
    chk("t3_post", 64'(post), 64'd5);

    // early drop by requester 1; pointer moves to 2 so 3 wins over a re-raised 1
    do_reset();
    req_v = 4'b1010;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) req_v = 4'b1000;
      if (c == 4) req_v = 4'b1010;
      settle();
      if (c == 1) chk("t4_owner1", 64'(owner), 64'd1);
      if (c == 3) chk("t4_drop_push", 64'(push), 64'd0);
      if (c == 4) chk("t4_idle", 64'(busy), 64'd0);
      if (c == 5) chk("t4_owner3", 64'(owner), 64'd3);
      advance();
    end

    // asynchronous reset in the middle of a burst
    do_reset();
    req_v = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      settle();
      advance();
    end
    chk("t5_pre_push", 64'(push), 64'd1);
    rst_v = 1'b0;
    model_reset();
    #1;
    chk("t5_push", 64'(push), 64'd0);
    chk("t5_gnt", 64'(gnt), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_din", 64'(din), 64'd0);
    settle();
    advance();
    req_v = 4'b1010;
    rst_v = 1'b1;
    settle();
    advance();
    settle();
    chk("t5_first_owner", 64'(owner), 64'd1);
    chk("t5_first_busy", 64'(busy), 64'd1);
    advance();

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req_v = 4'($urandom);
      full_v = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) data_v[i*DW +: DW] = $urandom;
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
